// File: rtl/periph_uart_tx_pkg.sv
// Shared constants, types and register map for the peripheral UART transmitter.
package periph_uart_pkg;

  localparam int unsigned ADDR_W = 31;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned DIV_W  = 16;

  localparam logic [1:0] REG_STATUS = 2'd0;
  localparam logic [1:0] REG_TXDATA = 2'd1;
  localparam logic [1:0] REG_BAUD   = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  localparam int unsigned STAT_FULL  = 0;
  localparam int unsigned STAT_EMPTY = 1;
  localparam int unsigned STAT_BUSY  = 2;
  localparam int unsigned STAT_OVF   = 3;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_tx_state_e;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } periph_req_t;

endpackage

// File: rtl/periph_uart_tx_if.sv
// Peripheral memory bus as seen by the UART transmitter.
interface periph_uart_tx_if;
  import periph_uart_pkg::*;

  logic              periph_mem_valid;
  logic [ADDR_W-1:0] periph_mem_addr;
  logic              periph_mem_write;
  logic [DATA_W-1:0] periph_mem_wdata;
  logic [STRB_W-1:0] periph_mem_wstrb;
  logic [DATA_W-1:0] periph_mem_rdata;
  logic              periph_mem_ready;

  modport master (
    output periph_mem_valid, periph_mem_addr, periph_mem_write,
           periph_mem_wdata, periph_mem_wstrb,
    input  periph_mem_rdata, periph_mem_ready
  );

  modport slave (
    input  periph_mem_valid, periph_mem_addr, periph_mem_write,
           periph_mem_wdata, periph_mem_wstrb,
    output periph_mem_rdata, periph_mem_ready
  );
endinterface

// File: rtl/periph_uart_tx_sync_fifo.sv
// Single-clock FIFO; a push into a full FIFO lands only if a pop frees a slot that cycle.
module sync_fifo #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic             do_push_c;
  logic             do_pop_c;

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign rdata     = mem[rd_ptr_q];
  assign do_pop_c  = pop & ~empty;
  assign do_push_c = push & (~full | do_pop_c);

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count    <= '0;
    end else begin
      if (do_push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count <= count + CNT_W'(do_push_c) - CNT_W'(do_pop_c);
    end
  end

  // Storage carries no reset; validity is tracked by count.
  always_ff @(posedge sys_clk) begin
    if (do_push_c) mem[wr_ptr_q] <= wdata;
  end
endmodule

// File: rtl/periph_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: bus decode, STATUS/TXDATA/BAUD_DIV registers, serialiser.
module periph_uart_tx
  import periph_uart_pkg::*;
#(
  parameter int unsigned      FIFO_DEPTH  = 16,
  parameter logic [DIV_W-1:0] DEFAULT_DIV = 16'd433
) (
  input  logic            sys_clk,
  input  logic            rst,
  periph_uart_tx_if.slave bus,
  output logic            uart_txd,
  output logic            tx_irq
);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  periph_req_t       req_c;
  logic [1:0]        reg_sel_c;
  logic              accept_c;
  logic              hold_q;
  logic              ready_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_c;
  logic [DIV_W-1:0]  baud_div_q;
  logic              overflow_q;
  logic              txdata_wr_c;
  logic              fifo_pop_c;
  logic              fifo_full;
  logic              fifo_empty;
  logic [7:0]        fifo_rdata;
  logic [CNT_W-1:0]  fifo_count;
  uart_tx_state_e    state_q;
  logic [7:0]        shift_q;
  logic [2:0]        bit_idx_q;
  logic [DIV_W-1:0]  baud_cnt_q;
  logic              unused_c;

  assign req_c = '{write: bus.periph_mem_write,
                   addr:  bus.periph_mem_addr,
                   wdata: bus.periph_mem_wdata,
                   wstrb: bus.periph_mem_wstrb};
  assign reg_sel_c = req_c.addr[3:2];

  // hold_q blocks re-acceptance until the master drops valid after its request.
  assign accept_c    = bus.periph_mem_valid & ~ready_q & ~hold_q;
  assign txdata_wr_c = accept_c & req_c.write & (reg_sel_c == REG_TXDATA) & req_c.wstrb[0];
  assign fifo_pop_c  = (state_q == IDLE) & ~fifo_empty;

  assign bus.periph_mem_ready = ready_q;
  assign bus.periph_mem_rdata = rdata_q;

  assign unused_c = ^{req_c.addr[ADDR_W-1:4], req_c.addr[1:0],
                      req_c.wdata[DATA_W-1:16], req_c.wstrb[STRB_W-1:2], fifo_count};

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .sys_clk (sys_clk),
    .rst     (rst),
    .push    (txdata_wr_c),
    .pop     (fifo_pop_c),
    .wdata   (req_c.wdata[7:0]),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Read data mux; TXDATA and the reserved slot read as zero.
  always_comb begin
    rdata_c = '0;
    case (reg_sel_c)
      REG_STATUS: begin
        rdata_c[STAT_FULL]  = fifo_full;
        rdata_c[STAT_EMPTY] = fifo_empty;
        rdata_c[STAT_BUSY]  = (state_q != IDLE);
        rdata_c[STAT_OVF]   = overflow_q;
      end
      REG_BAUD: rdata_c[DIV_W-1:0] = baud_div_q;
      default:  rdata_c = '0;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      ready_q    <= 1'b0;
      rdata_q    <= '0;
      hold_q     <= 1'b0;
      overflow_q <= 1'b0;
      baud_div_q <= DEFAULT_DIV;
    end else begin
      ready_q <= accept_c;
      rdata_q <= (accept_c && !req_c.write) ? rdata_c : '0;
      hold_q  <= bus.periph_mem_valid & (hold_q | accept_c);
      if (txdata_wr_c && fifo_full && !fifo_pop_c) begin
        overflow_q <= 1'b1;
      end else if (accept_c && req_c.write && reg_sel_c == REG_STATUS &&
                   req_c.wstrb[0] && req_c.wdata[STAT_OVF]) begin
        overflow_q <= 1'b0;
      end
      if (accept_c && req_c.write && reg_sel_c == REG_BAUD) begin
        if (req_c.wstrb[0]) baud_div_q[7:0]  <= req_c.wdata[7:0];
        if (req_c.wstrb[1]) baud_div_q[15:8] <= req_c.wdata[15:8];
      end
    end
  end

  // Serialiser: txd is registered alongside the state so each level lasts BAUD_DIV+1 cycles.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q    <= IDLE;
      uart_txd   <= 1'b1;
      tx_irq     <= 1'b1;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      baud_cnt_q <= '0;
    end else begin
      tx_irq <= fifo_empty & (state_q == IDLE);
      case (state_q)
        IDLE: begin
          uart_txd <= 1'b1;
          if (fifo_pop_c) begin
            shift_q    <= fifo_rdata;
            baud_cnt_q <= baud_div_q;
            uart_txd   <= 1'b0;
            state_q    <= START;
          end
        end
        START: begin
          if (baud_cnt_q == '0) begin
            state_q    <= DATA;
            bit_idx_q  <= '0;
            baud_cnt_q <= baud_div_q;
            uart_txd   <= shift_q[0];
          end else begin
            baud_cnt_q <= baud_cnt_q - DIV_W'(1);
          end
        end
        DATA: begin
          if (baud_cnt_q == '0) begin
            baud_cnt_q <= baud_div_q;
            shift_q    <= shift_q >> 1;
            if (bit_idx_q == 3'd7) begin
              state_q  <= STOP;
              uart_txd <= 1'b1;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              uart_txd  <= shift_q[1];
            end
          end else begin
            baud_cnt_q <= baud_cnt_q - DIV_W'(1);
          end
        end
        STOP: begin
          if (baud_cnt_q == '0) state_q <= IDLE;
          else                  baud_cnt_q <= baud_cnt_q - DIV_W'(1);
        end
        default: begin
          state_q  <= IDLE;
          uart_txd <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_periph_uart_tx.sv
// Directed self-checking bench for periph_uart_tx.
module tb_periph_uart_tx;
  import periph_uart_pkg::*;

  logic sys_clk = 1'b0;
  logic rst     = 1'b1;
  logic uart_txd;
  logic tx_irq;
  int   checks = 0;
  int   passes = 0;
  int   fails  = 0;
  int   cyc    = 0;

  periph_uart_tx_if bus_if();

  periph_uart_tx #(
    .FIFO_DEPTH  (16),
    .DEFAULT_DIV (16'd433)
  ) dut (
    .sys_clk  (sys_clk),
    .rst      (rst),
    .bus      (bus_if),
    .uart_txd (uart_txd),
    .tx_irq   (tx_irq)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_xfer(input logic wr, input logic [3:0] off, input logic [31:0] wd,
                          input logic [3:0] st, output logic [31:0] rd, output logic ok);
    @(posedge sys_clk); #1;
    bus_if.periph_mem_valid = 1'b1;
    bus_if.periph_mem_write = wr;
    bus_if.periph_mem_addr  = 31'(off);
    bus_if.periph_mem_wdata = wd;
    bus_if.periph_mem_wstrb = st;
    ok = 1'b0;
    rd = '0;
    for (int i = 0; i < 4 && !ok; i++) begin
      @(posedge sys_clk); #1;
      if (bus_if.periph_mem_ready) begin
        ok = 1'b1;
        rd = bus_if.periph_mem_rdata;
      end
    end
    bus_if.periph_mem_valid = 1'b0;
    bus_if.periph_mem_write = 1'b0;
  endtask

  task automatic wr_reg(input logic [3:0] off, input logic [31:0] wd, input logic [3:0] st,
                        input string tag);
    logic [31:0] rd;
    logic        ok;
    bus_xfer(1'b1, off, wd, st, rd, ok);
    check(32'(ok), 32'd1, {tag, "_ready"});
  endtask

  task automatic rd_reg(input logic [3:0] off, input logic [31:0] exp, input string tag);
    logic [31:0] rd;
    logic        ok;
    bus_xfer(1'b0, off, 32'd0, 4'h0, rd, ok);
    check(32'(ok), 32'd1, {tag, "_ready"});
    check(rd, exp, tag);
  endtask

  task automatic wait_low(input int limit, output logic found);
    found = 1'b0;
    for (int i = 0; i < limit && !found; i++) begin
      @(posedge sys_clk); #1;
      if (uart_txd == 1'b0) found = 1'b1;
    end
  endtask

  // Cycle-exact frame check; per[0]=start, per[1..8]=data bits, per[9]=stop.
  task automatic check_frame(input logic [7:0] b, input int per [10], input string tag);
    logic       found;
    logic [9:0] exp_bits;
    int         good;
    exp_bits = {1'b1, b, 1'b0};
    wait_low(2000, found);
    check(32'(found), 32'd1, {tag, "_start_seen"});
    if (found) begin
      for (int k = 0; k < 10; k++) begin
        good = 0;
        for (int c = 0; c < per[k]; c++) begin
          if (k != 0 || c != 0) begin
            @(posedge sys_clk); #1;
          end
          if (uart_txd === exp_bits[k]) good++;
        end
        check(32'(good), 32'(per[k]), $sformatf("%s_bit%0d_cycles", tag, k));
      end
    end
  endtask

  // Mid-bit sampling decoder for a known bit period.
  task automatic decode_byte(input int per, output logic [7:0] b, output logic found);
    b = 8'h00;
    wait_low(3000, found);
    if (found) begin
      repeat (per / 2) @(posedge sys_clk);
      #1;
      for (int k = 0; k < 8; k++) begin
        repeat (per) @(posedge sys_clk);
        #1;
        b[k] = uart_txd;
      end
      repeat (per) @(posedge sys_clk);
      #1;
      check(32'(uart_txd), 32'd1, "decode_stop_bit");
    end
  endtask

  initial begin
    logic        fa, fb;
    logic [7:0]  b;
    int          per [10];
    int          pulses;
    int          fall_cyc;

    bus_if.periph_mem_valid = 1'b0;
    bus_if.periph_mem_write = 1'b0;
    bus_if.periph_mem_addr  = '0;
    bus_if.periph_mem_wdata = '0;
    bus_if.periph_mem_wstrb = '0;
    fall_cyc = 0;

    repeat (3) @(posedge sys_clk);
    #1 rst = 1'b0;

    // Reset state and register map
    check(32'(uart_txd), 32'd1, "rst_txd");
    check(32'(tx_irq), 32'd1, "rst_irq");
    check(32'(bus_if.periph_mem_ready), 32'd0, "rst_ready");
    check(bus_if.periph_mem_rdata, 32'd0, "rst_rdata");
    rd_reg(4'h0, 32'h2, "rst_status");
    rd_reg(4'h8, 32'd433, "rst_baud");
    rd_reg(4'h4, 32'h0, "txdata_reads_zero");
    rd_reg(4'hC, 32'h0, "rsvd_reads_zero");
    @(posedge sys_clk); #1;
    check(32'(bus_if.periph_mem_ready), 32'd0, "idle_ready");
    check(bus_if.periph_mem_rdata, 32'd0, "idle_rdata");
    wr_reg(4'hC, 32'hFFFF_FFFF, 4'hF, "rsvd_write");
    wr_reg(4'h4, 32'h99, 4'h0, "txdata_no_strobe");
    repeat (4) @(posedge sys_clk);
    #1;
    check(32'(uart_txd), 32'd1, "no_strobe_txd");
    rd_reg(4'h0, 32'h2, "no_strobe_status");

    // BAUD_DIV byte strobes
    wr_reg(4'h8, 32'hFFFF_AB64, 4'h1, "baud_lo");
    rd_reg(4'h8, 32'h0164, "baud_lo_rb");
    wr_reg(4'h8, 32'h0000_1200, 4'h2, "baud_hi");
    rd_reg(4'h8, 32'h1264, "baud_hi_rb");
    wr_reg(4'h8, 32'hFFFF_0003, 4'hF, "baud_3");
    rd_reg(4'h8, 32'h0003, "baud_3_rb");

    // Framing of 0x55 at BAUD_DIV=3
    per = '{4, 4, 4, 4, 4, 4, 4, 4, 4, 4};
    fork
      check_frame(8'h55, per, "f55");
      begin
        wr_reg(4'h4, 32'h55, 4'h1, "f55_push");
        repeat (8) @(posedge sys_clk);
        #1;
        check(32'(tx_irq), 32'd0, "f55_irq_busy");
        rd_reg(4'h0, 32'h6, "f55_status_busy");
      end
    join
    repeat (3) @(posedge sys_clk);
    #1;
    check(32'(tx_irq), 32'd1, "f55_irq_after");
    rd_reg(4'h0, 32'h2, "f55_status_after");

    // valid held for three cycles on one TXDATA write
    fork
      check_frame(8'h3C, per, "hs");
      begin
        @(posedge sys_clk); #1;
        bus_if.periph_mem_valid = 1'b1;
        bus_if.periph_mem_write = 1'b1;
        bus_if.periph_mem_addr  = 31'h4;
        bus_if.periph_mem_wdata = 32'h3C;
        bus_if.periph_mem_wstrb = 4'h1;
        pulses = 0;
        repeat (3) begin
          @(posedge sys_clk); #1;
          if (bus_if.periph_mem_ready) pulses++;
        end
        bus_if.periph_mem_valid = 1'b0;
        bus_if.periph_mem_write = 1'b0;
        repeat (3) begin
          @(posedge sys_clk); #1;
          if (bus_if.periph_mem_ready) pulses++;
        end
        check(32'(pulses), 32'd1, "hs_ready_pulses");
      end
    join
    wait_low(200, fa);
    check(32'(fa), 32'd0, "hs_single_frame");

    // BAUD_DIV change during data bit 2 of 0xA5
    wr_reg(4'h8, 32'd7, 4'h3, "mid_baud7");
    per = '{8, 8, 8, 8, 4, 4, 4, 4, 4, 4};
    fork
      check_frame(8'hA5, per, "midbaud");
      begin
        wr_reg(4'h4, 32'hA5, 4'h1, "midbaud_push");
        wait_low(100, fb);
        repeat (26) @(posedge sys_clk);
        wr_reg(4'h8, 32'd3, 4'h3, "midbaud_baud3");
      end
    join
    repeat (3) @(posedge sys_clk);

    // Fill with the serialiser already busy so the 17th byte overflows
    wr_reg(4'h8, 32'd100, 4'h3, "fill_baud100");
    fork
      begin
        for (int n = 0; n < 17; n++) begin
          decode_byte(101, b, fa);
          check(32'({fa, b}), 32'({1'b1, 8'(8'h40 + n)}), $sformatf("fill_byte%0d", n));
        end
        wait_low(2500, fa);
        check(32'(fa), 32'd0, "fill_no_extra_frame");
      end
      begin
        wr_reg(4'h4, 32'h40, 4'h1, "fill_first");
        wait_low(200, fb);
        check(32'(fb), 32'd1, "fill_busy");
        for (int n = 1; n <= 17; n++) wr_reg(4'h4, 32'(32'h40 + n), 4'h1, "fill_push");
        rd_reg(4'h0, 32'hD, "fill_status_ovf");
        wr_reg(4'h0, 32'h8, 4'h1, "ovf_clear");
        rd_reg(4'h0, 32'h5, "ovf_cleared");
      end
    join

    // rst asserted in bit 4 with bytes queued
    wr_reg(4'h8, 32'd7, 4'h3, "rmid_baud7");
    fork
      begin
        wait_low(500, fa);
        fall_cyc = cyc;
      end
      begin
        wr_reg(4'h4, 32'h11, 4'h1, "rmid_push0");
        wr_reg(4'h4, 32'h22, 4'h1, "rmid_push1");
        wr_reg(4'h4, 32'h33, 4'h1, "rmid_push2");
      end
    join
    check(32'(fa), 32'd1, "rmid_start_seen");
    for (int i = 0; i < 200 && cyc < fall_cyc + 44; i++) begin
      @(posedge sys_clk); #1;
    end
    rd_reg(4'h0, 32'h4, "rmid_status_queued");
    rst = 1'b1;
    @(posedge sys_clk); #1;
    check(32'(uart_txd), 32'd1, "rmid_txd_high");
    @(posedge sys_clk); #1;
    rst = 1'b0;
    rd_reg(4'h0, 32'h2, "rmid_status");
    check(32'(tx_irq), 32'd1, "rmid_irq");
    rd_reg(4'h8, 32'd433, "rmid_baud_default");
    wait_low(600, fa);
    check(32'(fa), 32'd0, "rmid_no_frames");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/periph_uart_tx.md
Name: periph_uart_tx

Overview:
Memory-mapped UART transmitter on the CPU subsystem's peripheral memory bus, directly downstream of cpu_subsys_top.
- Accepts byte writes from the CPU into a TX FIFO and serialises them as 8N1 frames on a single TX pin.
- Exposes status and baud-divider registers so firmware can poll before writing.
- Replaces the behavioural character sink at offset 0x4 with real hardware.

Parameters:
FIFO_DEPTH, 16, TX FIFO entries; power of two, minimum 2.
DEFAULT_DIV, 16'd433, reset value of BAUD_DIV; bit period is BAUD_DIV+1 sys_clk cycles.

Ports:
sys_clk  in  1  system clock
rst  in  1  synchronous active-high reset
periph_mem_valid  in  1  bus request valid
periph_mem_addr  in  31  byte address; only [3:2] decoded
periph_mem_write  in  1  1 = write, 0 = read
periph_mem_wdata  in  32  write data
periph_mem_wstrb  in  4  byte strobes
periph_mem_rdata  out  32  read data, valid while ready=1
periph_mem_ready  out  1  one-cycle completion pulse
uart_txd  out  1  serial output, idle high
tx_irq  out  1  level high when FIFO is empty and the serialiser is idle

Behaviour:
- One clock domain (sys_clk). Reset is synchronous and active-high on rst.
- Reset values:
  - ready=0, rdata=0, uart_txd=1, tx_irq=1.
  - FIFO empty, serialiser IDLE, BAUD_DIV=DEFAULT_DIV, overflow=0.
- Bus handshake:
  - A request is accepted when valid=1 and ready=0.
  - ready is registered and pulses high for exactly one cycle, the cycle after acceptance.
  - rdata is driven in that same cycle and is 0 when ready=0.
  - Accepted requests take effect once; valid held high across the ready cycle is not re-accepted.
- Register map (addr[3:2]):
  - 0x0 STATUS.
    - Read: [0] fifo_full, [1] fifo_empty, [2] tx_busy (serialiser not IDLE), [3] overflow (sticky), [31:4]=0.
    - Write: if wstrb[0] and wdata[3]=1, overflow is cleared.
  - 0x4 TXDATA.
    - Write with wstrb[0]=1 pushes wdata[7:0]; wstrb[0]=0 does nothing.
    - Read returns 0.
  - 0x8 BAUD_DIV.
    - [15:0] is read/write, updated per byte strobe (wstrb[0], wstrb[1]).
    - [31:16] reads 0.
  - 0xC: reads 0, writes ignored, still completes with ready.
- Overflow: a TXDATA push while the FIFO is full drops the byte, sets overflow, and still completes with ready.
- FIFO:
  - Push is the accepted TXDATA write; pop is the serialiser load.
  - Push and pop in the same cycle are both honoured when full; pop proceeds when empty only after the push lands (next cycle).
  - Pointers wrap modulo FIFO_DEPTH; the count is $clog2(FIFO_DEPTH)+1 bits.
- Serialiser FSM, states IDLE, START, DATA, STOP:
  - IDLE: txd=1. If FIFO is not empty: pop into the shift register, load baud_cnt with BAUD_DIV, go to START.
  - START: txd=0 for BAUD_DIV+1 cycles, then DATA with bit_idx=0.
  - DATA: txd=shift[0] (LSB first); each bit lasts BAUD_DIV+1 cycles; shift right; after bit_idx=7, go to STOP.
  - STOP: txd=1 for BAUD_DIV+1 cycles, then IDLE.
  - Back-to-back: a byte popped in the IDLE cycle gives one extra idle cycle between frames. This is accepted behaviour.
- baud_cnt:
  - Reloads from BAUD_DIV at every bit start and counts down to 0.
  - A BAUD_DIV write mid-frame takes effect at the next bit boundary.
  - BAUD_DIV=0 gives a 1-cycle bit.
- tx_irq = fifo_empty & (state==IDLE), registered.
- rst asserted mid-frame: txd returns to 1 the next cycle and all FIFO contents are discarded.

Decomposition:
- Package periph_uart_pkg:
  - Register offset constants REG_STATUS/REG_TXDATA/REG_BAUD.
  - STATUS bit index constants.
  - Enum uart_tx_state_e {IDLE, START, DATA, STOP}.
- Sub-module sync_fifo: parameterised WIDTH/DEPTH, ports push/pop/wdata/rdata/full/empty/count, same sys_clk/rst. It is reused later by an RX block.
- Top level holds the bus decode, registers and serialiser FSM.

Test Plan:
- Reset: after rst, read 0x0 -> 0x2; uart_txd=1; tx_irq=1; read 0x8 -> DEFAULT_DIV.
- Framing:
  - Stimulus: write 0x8=3, then write 0x4=0x55.
  - Response: txd low 4 cycles, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, then high 4 cycles; tx_busy=1 during the frame; tx_irq rises after STOP.
- Fill:
  - Stimulus: with BAUD_DIV=100, write 17 bytes 0x41..0x51 back-to-back.
  - Response: read 0x0 shows overflow=1 and full=1. Monitor decodes 0x41..0x50; 0x51 is absent.
  - Then write 0x0=0x8 -> overflow reads 0.
- Handshake: hold valid high for 3 cycles on one TXDATA write -> ready pulses exactly once and exactly one byte is transmitted.
- Mid-frame baud change: during the DATA bit 2 of 0xA5 at BAUD_DIV=7, write BAUD_DIV=3 -> bit 2 stays 8 cycles, bit 3 onward lasts 4 cycles.
- Reset mid-frame: assert rst in bit 4 with 3 bytes queued -> txd=1 the next cycle, STATUS=0x2 after release, no further frames.
